// File: rtl/reg_dump_reader_if.sv
// Valid/ready beat stream carrying register-dump data out of reg_dump_reader.
interface reg_dump_reader_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] DOUT_DATA;
    logic [ADDR_WIDTH-1:0] DOUT_ADDR;
    logic                  DOUT_LAST;
    logic                  DOUT_VALID;
    logic                  DOUT_READY;

    modport master (output DOUT_DATA, DOUT_ADDR, DOUT_LAST, DOUT_VALID, input DOUT_READY);
    modport slave  (input DOUT_DATA, DOUT_ADDR, DOUT_LAST, DOUT_VALID, output DOUT_READY);
endinterface

// File: rtl/reg_dump_reader.sv
// Sweeps the register file read port on START and streams every register out as one beat.
// Optional REG_DUMP_CHECKSUM_EN appends one XOR-checksum beat (addr 0, LAST=1) to each sweep.
module reg_dump_reader #(
    parameter int NUM_REGS      = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    output logic [ADDR_WIDTH-1:0] RF_ADDRESS,
    input  logic [DATA_WIDTH-1:0] RF_DATA,
    reg_dump_reader_if.master     dout,
    output logic                  BUSY,
    output logic                  DONE
);
    typedef enum logic [1:0] {IDLE, SETUP, SEND, FIN} state_t;

    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]      CNT_INIT  = CNT_W'(SETTLE_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             last_reg;

    assign xfer     = dout.DOUT_VALID & dout.DOUT_READY;
    assign last_reg = (RF_ADDRESS == LAST_ADDR);

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] chk_acc;
    logic                  chk_beat;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        BUSY      = (state != IDLE);
        DONE      = (state == FIN);
        case (state)
            IDLE:  if (START) state_nxt = SETUP;
            SETUP: if (cnt == '0) state_nxt = SEND;
            SEND:
                if (xfer) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    if (chk_beat)      state_nxt = FIN;
                    else if (last_reg) state_nxt = SEND;
                    else               state_nxt = SETUP;
`else
                    state_nxt = last_reg ? FIN : SETUP;
`endif
                end
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beat registers are loaded once per register; RF_DATA is not looked at again in SEND.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RF_ADDRESS      <= '0;
            cnt             <= '0;
            dout.DOUT_DATA  <= '0;
            dout.DOUT_ADDR  <= '0;
            dout.DOUT_LAST  <= 1'b0;
            dout.DOUT_VALID <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            chk_acc         <= '0;
            chk_beat        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:
                    if (START) begin
                        RF_ADDRESS <= '0;
                        cnt        <= CNT_INIT;
`ifdef REG_DUMP_CHECKSUM_EN
                        chk_acc    <= '0;
                        chk_beat   <= 1'b0;
`endif
                    end
                SETUP:
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        dout.DOUT_DATA  <= RF_DATA;
                        dout.DOUT_ADDR  <= RF_ADDRESS;
                        dout.DOUT_VALID <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                        dout.DOUT_LAST  <= 1'b0;
                        chk_acc         <= chk_acc ^ RF_DATA;
`else
                        dout.DOUT_LAST  <= last_reg;
`endif
                    end
                SEND:
                    if (xfer) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        if (chk_beat) begin
                            dout.DOUT_VALID <= 1'b0;
                            dout.DOUT_LAST  <= 1'b0;
                            chk_beat        <= 1'b0;
                        end else if (last_reg) begin
                            // Trailing checksum beat follows directly, VALID stays high.
                            dout.DOUT_DATA <= chk_acc;
                            dout.DOUT_ADDR <= '0;
                            dout.DOUT_LAST <= 1'b1;
                            chk_beat       <= 1'b1;
                        end else begin
                            RF_ADDRESS      <= RF_ADDRESS + 1'b1;
                            cnt             <= CNT_INIT;
                            dout.DOUT_VALID <= 1'b0;
                        end
`else
                        if (last_reg) begin
                            dout.DOUT_VALID <= 1'b0;
                            dout.DOUT_LAST  <= 1'b0;
                        end else begin
                            RF_ADDRESS      <= RF_ADDRESS + 1'b1;
                            cnt             <= CNT_INIT;
                            dout.DOUT_VALID <= 1'b0;
                        end
`endif
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader: expected beats come from a queue built off a register-file snapshot.
module tb_reg_dump_reader;
    localparam int N      = 8;
    localparam int AW     = 3;
    localparam int DW     = 8;
    localparam int SETTLE = 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] rf_address;
    logic [DW-1:0] rf_data;
    logic          busy, done;
    logic [DW-1:0] regs [N];

    int n_checks = 0;
    int n_errors = 0;

    reg_dump_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dout();

    reg_dump_reader #(.NUM_REGS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK(clk), .RESET(rst), .START(start),
        .RF_ADDRESS(rf_address), .RF_DATA(rf_data),
        .dout(dout), .BUSY(busy), .DONE(done)
    );

    assign rf_data = regs[rf_address];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_valid"}, dout.DOUT_VALID, 0);
        chk({tag, "_data"},  dout.DOUT_DATA, 0);
        chk({tag, "_addr"},  dout.DOUT_ADDR, 0);
        chk({tag, "_last"},  dout.DOUT_LAST, 0);
        chk({tag, "_rfaddr"}, rf_address, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
    endtask

    // rmode 0: READY always high, 1: random READY. Negative addr arguments disable that feature.
    task automatic run_sweep(input int rmode, input int stall_addr, input int poke_addr,
                             input bit spam, input int abort_addr);
        beat_t         exp_q[$];
        beat_t         b, held, cur;
        bit            held_v = 0, first_v = 0, stalled = 0, poked = 0;
        int            cyc = 0, done_due = -1, stall_left = 0;
        logic [DW-1:0] x = '0;
        logic          rdy;

        for (int i = 0; i < N; i++) begin
            b.a = AW'(i);
            b.d = regs[i];
            x  ^= regs[i];
`ifdef REG_DUMP_CHECKSUM_EN
            b.l = 1'b0;
`else
            b.l = (i == N - 1);
`endif
            exp_q.push_back(b);
        end
`ifdef REG_DUMP_CHECKSUM_EN
        b.a = '0; b.d = x; b.l = 1'b1;
        exp_q.push_back(b);
`endif

        @(negedge clk);
        start = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cyc > 1000) begin
                chk("timeout", 1, 0);
                break;
            end
            if (cyc == done_due) begin
                chk("done", done, 1);
                chk("done_busy", busy, 1);
                chk("done_valid", dout.DOUT_VALID, 0);
                if (spam) start = 1'b1;
                break;
            end
            chk("early_done", done, 0);
            cur.a = dout.DOUT_ADDR; cur.d = dout.DOUT_DATA; cur.l = dout.DOUT_LAST;
            if (held_v) begin
                chk("hold_valid", dout.DOUT_VALID, 1);
                chk("hold_data", cur.d, held.d);
                chk("hold_addr", cur.a, held.a);
                chk("hold_last", cur.l, held.l);
            end
            if (dout.DOUT_VALID && !first_v) begin
                first_v = 1;
                chk("latency", cyc, SETTLE + 2);
            end
            if (dout.DOUT_VALID && abort_addr >= 0 && int'(cur.a) == abort_addr) begin
                rst = 1'b1;
                #1;
                chk_zero_outs("abort");
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                dout.DOUT_READY = 1'b0;
                return;
            end
            if (dout.DOUT_VALID && poke_addr >= 0 && int'(cur.a) == poke_addr && !poked) begin
                poked = 1;
                regs[poke_addr] = 8'hAA;
            end
            rdy = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            if (dout.DOUT_VALID && stall_addr >= 0 && int'(cur.a) == stall_addr && !stalled) begin
                stalled = 1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
                chk("stall_valid", dout.DOUT_VALID, 1);
                if (exp_q.size() > 0) chk("stall_data", cur.d, exp_q[0].d);
            end
            dout.DOUT_READY = rdy;
            if (dout.DOUT_VALID && rdy) begin
                held_v = 0;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", dout.DOUT_VALID, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_addr", cur.a, b.a);
                    chk("beat_data", cur.d, b.d);
                    chk("beat_last", cur.l, b.l);
                    if (exp_q.size() == 0) done_due = cyc + 1;
                end
            end else if (dout.DOUT_VALID) begin
                held = cur;
                held_v = 1;
            end else begin
                held_v = 0;
            end
        end

        @(negedge clk);
        start = 1'b0;
        dout.DOUT_READY = 1'b0;
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("beats_left", exp_q.size(), 0);
        repeat (5) begin
            @(negedge clk);
            chk("idle_valid", dout.DOUT_VALID, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_rfaddr", rf_address, N - 1);
        end
    endtask

    initial begin
        dout.DOUT_READY = 1'b0;
        for (int i = 0; i < N; i++) regs[i] = 8'(8'h10 + i);
        repeat (2) @(negedge clk);
        chk_zero_outs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero_outs("idle0");

        run_sweep(0, -1, -1, 0, -1);   // plain sweep, READY high
        run_sweep(0, 3, -1, 0, -1);    // 5-cycle stall on beat 3
        run_sweep(0, -1, 2, 0, -1);    // reg 2 rewritten after capture
        regs[2] = 8'h12;
        run_sweep(0, -1, -1, 0, 4);    // reset during beat 4
        repeat (3) begin
            @(negedge clk);
            chk_zero_outs("after_abort");
        end
        run_sweep(0, -1, -1, 0, -1);
        run_sweep(1, -1, -1, 1, -1);   // START spam while busy and in FIN

        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < N; i++) regs[i] = 8'($urandom);
            run_sweep(1, int'($urandom_range(0, N - 1)), -1, 0, -1);
        end

`ifdef REG_DUMP_CHECKSUM_EN
        for (int i = 0; i < N; i++) regs[i] = 8'(1 << i);
        run_sweep(0, -1, -1, 0, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
